// File: rtl/charbuf_pkg.sv
// -----------------------------------------------------------------------------
// charbuf_pkg
// Shared definitions for the terminal-style character buffer:
//   - control codes recognised by the writer (LF, CR, BS)
//   - writer/clear state encoding
// Optional feature macro (consumed by charbuf_term): CHARBUF_SCROLL_EN
// -----------------------------------------------------------------------------
package charbuf_pkg;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    // Compare a character of arbitrary width against an 8-bit control code.
    function automatic logic code_match(input logic [31:0] ch, input logic [7:0] code);
        return ch == {24'h0, code};
    endfunction

endpackage

// File: rtl/charbuf_ram.sv
// -----------------------------------------------------------------------------
// charbuf_ram
// Simple dual-port RAM, single clock, read-first, registered read data.
// Coded so synthesis maps the array onto a block RAM in simple dual-port mode;
// only the output register carries a reset.
//
// Ports:
//   clk     in   clock for both ports
//   resetn  in   async active-low reset (clears the read register only)
//   we      in   write enable
//   waddr   in   write address [AW]
//   wdata   in   write data [WIDTH]
//   re      in   read enable; rdata holds when low
//   raddr   in   read address [AW]
//   rdata   out  registered read data [WIDTH]
// -----------------------------------------------------------------------------
module charbuf_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking update of mem means a same-edge write is not visible here:
    // a collision returns the old contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/charbuf_term.sv
// -----------------------------------------------------------------------------
// charbuf_term
// Character buffer with a terminal-style writer. One character is accepted per
// wr_valid/wr_ready handshake and placed at an auto-advancing cursor. LF, CR
// and BS move the cursor; everything else is stored. Screen scroll is done by
// rotating a physical row offset (top) and blanking the new bottom row.
//
// Configuration macro: CHARBUF_SCROLL_EN
//   defined   - advancing past the last row scrolls the screen
//   undefined - advancing past the last row wraps the cursor to row 0
//
// Ports:
//   clk      in   single clock
//   resetn   in   async active-low reset
//   wr_valid in   character offered
//   wr_ready out  writer can accept (IDLE and no cls this cycle)
//   wr_char  in   character code [CHAR_W]
//   cls      in   single-cycle clear-screen request
//   rd_en    in   renderer read strobe
//   rd_col   in   logical column
//   rd_row   in   logical row (0 = top of screen)
//   rd_char  out  registered cell contents, valid one cycle after rd_en
//   cur_col  out  cursor column
//   cur_row  out  cursor logical row
//   busy     out  clear sequence in progress
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | accepting characters
// CLR_ROW | blanking the freshly exposed bottom row after a scroll
// CLR_ALL | blanking every cell (after reset or cls)
// -----------------------------------------------------------------------------
module charbuf_term
    import charbuf_pkg::*;
#(
    parameter int                COLS   = 32,
    parameter int                ROWS   = 32,
    parameter int                CHAR_W = 8,
    parameter logic [CHAR_W-1:0] BLANK  = '0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [CHAR_W-1:0]        wr_char,
    input  logic                     cls,
    input  logic                     rd_en,
    input  logic [$clog2(COLS)-1:0]  rd_col,
    input  logic [$clog2(ROWS)-1:0]  rd_row,
    output logic [CHAR_W-1:0]        rd_char,
    output logic [$clog2(COLS)-1:0]  cur_col,
    output logic [$clog2(ROWS)-1:0]  cur_row,
    output logic                     busy
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = CW + RW;
    localparam int DEPTH = COLS * ROWS;

    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [RW-1:0] top;

    logic          take;
    logic          is_lf;
    logic          is_cr;
    logic          is_bs;
    logic          is_print;
    logic          row_adv;
    logic          scroll;

    logic [RW-1:0] wr_phys_row;
    logic [RW-1:0] bot_phys_row;
    logic [RW-1:0] rd_phys_row;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [CHAR_W-1:0] ram_wdata;
    logic [AW-1:0]     ram_raddr;

    // ------------------------------------------------------------------
    // Handshake and character classification
    // ------------------------------------------------------------------
    assign wr_ready = (state == IDLE) && !cls;
    assign busy     = (state != IDLE);
    assign take     = wr_valid && wr_ready;

    assign is_lf    = code_match(32'(wr_char), CH_LF);
    assign is_cr    = code_match(32'(wr_char), CH_CR);
    assign is_bs    = code_match(32'(wr_char), CH_BS);
    assign is_print = !(is_lf || is_cr || is_bs);

    // A printable character in the last column wraps like an LF.
    assign row_adv  = take && (is_lf || (is_print && (cur_col == COL_MAX)));

`ifdef CHARBUF_SCROLL_EN
    assign scroll   = row_adv && (cur_row == ROW_MAX);
`else
    assign scroll   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Logical-to-physical row translation; all sums wrap mod ROWS.
    // bot_phys_row is evaluated with the already-advanced top, so in
    // CLR_ROW it points at the row that just scrolled into view.
    // ------------------------------------------------------------------
    assign wr_phys_row  = cur_row + top;
    assign bot_phys_row = ROW_MAX + top;
    assign rd_phys_row  = rd_row + top;
    assign ram_raddr    = {rd_phys_row, rd_col};

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {wr_phys_row, cur_col};
        ram_wdata = wr_char;
        case (state)
            IDLE: begin
                ram_we = take && is_print;
            end
            CLR_ROW: begin
                ram_we    = 1'b1;
                ram_waddr = {bot_phys_row, clr_cnt[CW-1:0]};
                ram_wdata = BLANK;
            end
            CLR_ALL: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = BLANK;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Writer FSM, cursor and scroll offset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= CLR_ALL;
            clr_cnt <= '0;
            top     <= '0;
            cur_col <= '0;
            cur_row <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cls) begin
                        state   <= CLR_ALL;
                        clr_cnt <= '0;
                        top     <= '0;
                        cur_col <= '0;
                        cur_row <= '0;
                    end else if (take) begin
                        if (is_lf || is_cr) begin
                            cur_col <= '0;
                        end else if (is_bs) begin
                            if (cur_col != '0) begin
                                cur_col <= cur_col - CW'(1);
                            end
                        end else begin
                            // Wraps to 0 from COL_MAX on its own.
                            cur_col <= cur_col + CW'(1);
                        end

                        // Without scroll this also wraps ROW_MAX -> 0.
                        if (row_adv && !scroll) begin
                            cur_row <= cur_row + RW'(1);
                        end

                        if (scroll) begin
                            top     <= top + RW'(1);
                            clr_cnt <= '0;
                            state   <= CLR_ROW;
                        end
                    end
                end

                CLR_ROW: begin
                    if (cls) begin
                        state   <= CLR_ALL;
                        clr_cnt <= '0;
                        top     <= '0;
                        cur_col <= '0;
                        cur_row <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                        if (clr_cnt[CW-1:0] == COL_MAX) begin
                            state <= IDLE;
                        end
                    end
                end

                CLR_ALL: begin
                    // cls is deliberately ignored while a full clear runs.
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == CNT_MAX) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= CLR_ALL;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Cell storage
    // ------------------------------------------------------------------
    charbuf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_W),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .re     (rd_en),
        .raddr  (ram_raddr),
        .rdata  (rd_char)
    );

endmodule

// File: tb/tb_charbuf_term.sv
// -----------------------------------------------------------------------------
// tb_charbuf_term
// Directed bench for charbuf_term at 32x32, 8-bit cells. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_charbuf_term;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_char;
    logic       cls;
    logic       rd_en;
    logic [4:0] rd_col;
    logic [4:0] rd_row;
    logic [7:0] rd_char;
    logic [4:0] cur_col;
    logic [4:0] cur_row;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    charbuf_term #(
        .COLS   (32),
        .ROWS   (32),
        .CHAR_W (8),
        .BLANK  (8'h00)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_char  (wr_char),
        .cls      (cls),
        .rd_en    (rd_en),
        .rd_col   (rd_col),
        .rd_row   (rd_row),
        .rd_char  (rd_char),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        while (!wr_ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_wait: wr_ready=%b required 1 (char %02h)", wr_ready, c);
        end
        wr_valid = 1'b1;
        wr_char  = c;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic read_cell(input int col, input int row, output logic [7:0] d);
        rd_col = 5'(col);
        rd_row = 5'(row);
        rd_en  = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        d     = rd_char;
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] d;
        resetn   = 1'b0;
        wr_valid = 1'b0;
        wr_char  = 8'h00;
        cls      = 1'b0;
        rd_en    = 1'b0;
        rd_col   = '0;
        rd_row   = '0;
        #22;
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: busy=%b wr_ready=%b required 1 0", busy, wr_ready);
        end
        checks++;
        if (rd_char !== 8'h00 || cur_col !== 5'd0 || cur_row !== 5'd0) begin
            fails++;
            $display("FAIL reset_outs: rd_char=%h cur=(%0d,%0d) required 00 (0,0)",
                     rd_char, cur_col, cur_row);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 1024) begin
            fails++;
            $display("FAIL reset_busy_len: busy cycles=%0d required 1024", n);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: wr_ready=%b required 1", wr_ready);
        end
        read_cell(0, 0, d);
        checks++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_cell_0_0: got %h required 00", d);
        end
        read_cell(31, 31, d);
        checks++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_cell_31_31: got %h required 00", d);
        end
        read_cell(5, 17, d);
        checks++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_cell_5_17: got %h required 00", d);
        end
    endtask

    task automatic test_write_basic();
        logic [7:0] d;
        send_char(8'h41);
        send_char(8'h42);
        checks++;
        if (cur_col !== 5'd2 || cur_row !== 5'd0) begin
            fails++;
            $display("FAIL basic_cursor: got (%0d,%0d) required (2,0)", cur_col, cur_row);
        end
        read_cell(0, 0, d);
        checks++;
        if (d !== 8'h41) begin
            fails++;
            $display("FAIL basic_cell_0_0: got %h required 41", d);
        end
        // rd_en low: rd_char must hold while the address moves
        rd_col = 5'd1;
        @(posedge clk);
        #1;
        checks++;
        if (rd_char !== 8'h41) begin
            fails++;
            $display("FAIL read_hold: got %h required 41", rd_char);
        end
        read_cell(1, 0, d);
        checks++;
        if (d !== 8'h42) begin
            fails++;
            $display("FAIL basic_cell_1_0: got %h required 42", d);
        end
    endtask

    task automatic test_row_fill();
        logic [7:0] d;
        send_char(8'h0D);
        for (int i = 0; i < 32; i++) send_char(8'h55);
        checks++;
        if (cur_col !== 5'd0 || cur_row !== 5'd1) begin
            fails++;
            $display("FAIL fill_cursor: got (%0d,%0d) required (0,1)", cur_col, cur_row);
        end
        for (int c = 0; c < 32; c++) begin
            read_cell(c, 0, d);
            checks++;
            if (d !== 8'h55) begin
                fails++;
                $display("FAIL fill_cell_%0d: got %h required 55", c, d);
            end
        end
    endtask

    task automatic test_ctrl_codes();
        logic [7:0] d;
        // cursor at (0,1)
        send_char(8'h08);
        checks++;
        if (cur_col !== 5'd0 || cur_row !== 5'd1) begin
            fails++;
            $display("FAIL bs_at_col0: got (%0d,%0d) required (0,1)", cur_col, cur_row);
        end
        for (int i = 0; i < 7; i++) send_char(8'h31);
        checks++;
        if (cur_col !== 5'd7) begin
            fails++;
            $display("FAIL ctrl_col7: got %0d required 7", cur_col);
        end
        send_char(8'h0D);
        checks++;
        if (cur_col !== 5'd0 || cur_row !== 5'd1) begin
            fails++;
            $display("FAIL cr_col7: got (%0d,%0d) required (0,1)", cur_col, cur_row);
        end
        for (int i = 0; i < 3; i++) send_char(8'h32);
        send_char(8'h08);
        checks++;
        if (cur_col !== 5'd2) begin
            fails++;
            $display("FAIL bs_col3: got %0d required 2", cur_col);
        end
        read_cell(2, 1, d);
        checks++;
        if (d !== 8'h32) begin
            fails++;
            $display("FAIL bs_no_erase: got %h required 32", d);
        end
        read_cell(5, 1, d);
        checks++;
        if (d !== 8'h31) begin
            fails++;
            $display("FAIL cr_keeps_cell: got %h required 31", d);
        end
    endtask

    task automatic test_cls();
        int n;
        logic [7:0] d;
        cls      = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 8'h55;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL cls_ready: wr_ready=%b required 0", wr_ready);
        end
        @(posedge clk);
        #1;
        cls      = 1'b0;
        wr_valid = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 1024) begin
            fails++;
            $display("FAIL cls_busy_len: busy cycles=%0d required 1024", n);
        end
        checks++;
        if (cur_col !== 5'd0 || cur_row !== 5'd0) begin
            fails++;
            $display("FAIL cls_cursor: got (%0d,%0d) required (0,0)", cur_col, cur_row);
        end
        read_cell(2, 1, d);
        checks++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL cls_cell_2_1: got %h required 00", d);
        end
        read_cell(10, 0, d);
        checks++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL cls_cell_10_0: got %h required 00", d);
        end
        read_cell(0, 0, d);
        checks++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL cls_dropped_char: got %h required 00", d);
        end
    endtask

`ifdef CHARBUF_SCROLL_EN
    task automatic test_scroll();
        int n;
        logic [7:0] d;
        // cursor (0,0) after cls
        for (int i = 0; i < 32; i++) send_char(8'h41);
        for (int i = 0; i < 32; i++) send_char(8'h42);
        for (int i = 0; i < 29; i++) send_char(8'h0A);
        for (int i = 0; i < 5; i++) send_char(8'h43);
        checks++;
        if (cur_col !== 5'd5 || cur_row !== 5'd31) begin
            fails++;
            $display("FAIL scroll_setup: got (%0d,%0d) required (5,31)", cur_col, cur_row);
        end
        send_char(8'h0A);
        n = 0;
        while (!wr_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 32) begin
            fails++;
            $display("FAIL scroll_stall: wr_ready low for %0d cycles required 32", n);
        end
        checks++;
        if (cur_col !== 5'd0 || cur_row !== 5'd31) begin
            fails++;
            $display("FAIL scroll_cursor: got (%0d,%0d) required (0,31)", cur_col, cur_row);
        end
        for (int c = 0; c < 32; c++) begin
            read_cell(c, 0, d);
            checks++;
            if (d !== 8'h42) begin
                fails++;
                $display("FAIL scroll_row0_%0d: got %h required 42", c, d);
            end
            read_cell(c, 31, d);
            checks++;
            if (d !== 8'h00) begin
                fails++;
                $display("FAIL scroll_row31_%0d: got %h required 00", c, d);
            end
        end
        read_cell(4, 30, d);
        checks++;
        if (d !== 8'h43) begin
            fails++;
            $display("FAIL scroll_row30: got %h required 43", d);
        end
    endtask
`else
    task automatic test_wrap();
        // cursor (0,0) after cls
        for (int i = 0; i < 31; i++) send_char(8'h0A);
        checks++;
        if (cur_row !== 5'd31) begin
            fails++;
            $display("FAIL wrap_setup: cur_row=%0d required 31", cur_row);
        end
        send_char(8'h0A);
        checks++;
        if (cur_row !== 5'd0 || cur_col !== 5'd0) begin
            fails++;
            $display("FAIL wrap_row: got (%0d,%0d) required (0,0)", cur_col, cur_row);
        end
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL wrap_busy: busy=%b wr_ready=%b required 0 1", busy, wr_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_row_fill();
        test_ctrl_codes();
        test_cls();
`ifdef CHARBUF_SCROLL_EN
        test_scroll();
`else
        test_wrap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
